bridge_timer: RTL and testbench
===============================

Name: bridge_timer

Overview:
- Store-side counterpart to the datapath's read-select muxes.
- Decodes a CPU data-memory access, steers the write strobe to one of two on-chip timers (TC0/TC1), and returns the addressed register on the read port.
- Sits between the MEM stage and the peripheral space; drives the interrupt lines to the CP0 block.

Parameters:
- BASE0, 32'h0000_7F00, TC0 window base; compared on addr[31:4].
- BASE1, 32'h0000_7F10, TC1 window base; compared on addr[31:4].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from MEM stage; addr[1:0] ignored.
- we  in  1  word write strobe.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr.
- hit  out  1  addr maps to a valid timer register.
- irq  out  2  irq[0]=TC0, irq[1]=TC1, level.

Behaviour:
- Register map per timer, offset addr[3:2]:
  - 0 = CTRL (RW)
  - 1 = PRESET (RW)
  - 2 = COUNT (RO)
  - 3 = unmapped: hit=0, rdata=0, writes dropped.
- Addresses outside both windows: hit=0, rdata=0, no register changes.
- CTRL bits:
  - [0] EN.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 00.
  - [3] IM, interrupt mask.
  - [31:4] read as 0 and are not stored.
- Writes take effect at the next rising clk edge. Reads are same-cycle, zero latency.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0, irq=0. Reset mid-count aborts immediately with no irq.
- Per-timer FSM, evaluated every cycle:
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT held.
    - COUNT>1 -> COUNT-1.
    - COUNT<=1 -> COUNT<=0, -> INT.
  - INT: pending<=1.
    - MODE 00: EN<=0, -> IDLE.
    - MODE 01: -> LOAD.
- PRESET=0 or 1: a single CNT cycle, then INT.
- Interrupt output: irq[n] = pending[n] & IM[n].
  - MODE 00: pending stays set until any write to that timer's CTRL or PRESET.
  - MODE 01: pending clears automatically one cycle after being set, giving a one-cycle pulse.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears EN: CPU value wins.
  - A CPU write that clears pending in the same cycle INT sets it: set wins.
  - A PRESET write during CNT does not disturb COUNT; it is used at the next LOAD.
  - Clearing EN while in INT: the FSM still completes INT (pending set), then goes to IDLE regardless of MODE.
- TC0 and TC1 are fully independent. we only affects the timer whose window matches.

Optional Feature:
- Macro TC_COUNT_WRITE_EN.
- Defined: offset 2 is RW. A write sets COUNT<=wdata at the next edge, overriding any FSM update that cycle. The FSM state is unchanged, so a write of 0 in CNT reaches INT next cycle.
- Undefined: writes to offset 2 are dropped; hit is still 1 for reads.

Test Plan:
- Reset, read 0x7F00/0x7F04/0x7F08/0x7F14 -> rdata=0, hit=1; read 0x7F0C and 0x8000 -> hit=0, rdata=0.
- TC0: PRESET=5, CTRL=0x9 (EN, MODE 00, IM) -> COUNT 5,4,3,2,1,0 on successive cycles after LOAD. irq[0] rises the cycle after COUNT=0 and stays high; CTRL reads 0x8 (EN cleared). A write of CTRL=0x8 drops irq[0] next cycle.
- TC1: PRESET=3, CTRL=0xB (auto-reload) -> irq[1] one-cycle pulse every 5 cycles (LOAD + 3 CNT + INT), repeating. Writing CTRL=0 mid-count stops COUNT at its current value with no further pulses.
- CTRL=0x1 (IM=0), PRESET=2 -> timer reaches INT and EN clears, irq stays 0. A later write of CTRL=0x8 leaves irq=0 because the write clears pending.
- Same-cycle write of CTRL=0x9 on the cycle TC0 enters INT in MODE 00 -> EN reads 1 afterward and the timer reloads via IDLE->LOAD; pending=1 and irq[0]=1.
- With TC_COUNT_WRITE_EN: during CNT at COUNT=100, write 0x7F08=0 -> INT next cycle. Without the macro the same write leaves COUNT decrementing from 100.

Source files
------------

// File: rtl/bridge_timer.sv
// rtl/bridge_timer.sv - CPU data-memory decode and write steering for two on-chip timers TC0/TC1
//
// Decodes a MEM-stage word access, steers the write strobe to the timer whose
// 16-byte window matches addr[31:4], and returns the addressed register
// combinationally. Each timer runs an IDLE/LOAD/CNT/INT sequencer and raises
// a level interrupt gated by its CTRL.IM bit.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   addr   - byte address, addr[3:2] selects CTRL/PRESET/COUNT, addr[1:0] ignored
//   we     - word write strobe
//   wdata  - write data
//   rdata  - read data, zero latency, 0 when hit=0
//   hit    - addr maps to a valid timer register
//   irq    - irq[0]=TC0, irq[1]=TC1, pending & IM
//
// Optional macro TC_COUNT_WRITE_EN: makes COUNT (offset 2) writable; a write
// overrides that cycle's sequencer update of COUNT without changing its state.

module bridge_timer #(
    parameter logic [31:0] BASE0 = 32'h0000_7F00,
    parameter logic [31:0] BASE1 = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [1:0]  irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INTR = 2'd3
    } state_t;

    logic [1:0]  sel;
    logic [1:0]  off;
    logic [31:0] rd_val [2];
    logic        unused_addr;

    assign sel[0]      = (addr[31:4] == BASE0[31:4]);
    assign sel[1]      = (addr[31:4] == BASE1[31:4]);
    assign off         = addr[3:2];
    assign unused_addr = ^addr[1:0];

    assign hit   = (|sel) && (off != 2'd3);
    assign rdata = !hit ? 32'd0 : (sel[0] ? rd_val[0] : rd_val[1]);

    for (genvar i = 0; i < 2; i++) begin : g_tc
        state_t      state, state_n;
        logic        en, en_n;
        logic [1:0]  mode, mode_n;
        logic        im, im_n;
        logic [31:0] preset, preset_n;
        logic [31:0] count, count_n;
        logic        pending, pending_n;
        logic        wr_ctrl, wr_preset;
        logic        auto_reload;
        logic        set_pend;

        assign wr_ctrl     = we && sel[i] && (off == 2'd0);
        assign wr_preset   = we && sel[i] && (off == 2'd1);
        // MODE 1x behaves as one-shot
        assign auto_reload = (mode == 2'b01);

`ifdef TC_COUNT_WRITE_EN
        logic wr_count;
        assign wr_count = we && sel[i] && (off == 2'd2);
`endif

        always_comb begin
            state_n   = state;
            en_n      = en;
            mode_n    = mode;
            im_n      = im;
            preset_n  = preset;
            count_n   = count;
            pending_n = pending;
            set_pend  = 1'b0;

            case (state)
                IDLE: begin
                    if (en) state_n = LOAD;
                end
                LOAD: begin
                    count_n = preset;
                    state_n = CNT;
                end
                CNT: begin
                    if (!en) begin
                        state_n = IDLE;
                    end else if (count > 32'd1) begin
                        count_n = count - 32'd1;
                    end else begin
                        count_n = 32'd0;
                        state_n = INTR;
                    end
                end
                INTR: begin
                    set_pend = 1'b1;
                    // EN already cleared by software forces IDLE even in auto-reload
                    if (!en || !auto_reload) begin
                        en_n    = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = LOAD;
                    end
                end
                default: state_n = IDLE;
            endcase

            // Set beats any clear; auto-reload turns pending into a one-cycle pulse
            if (set_pend)
                pending_n = 1'b1;
            else if (wr_ctrl || wr_preset || auto_reload)
                pending_n = 1'b0;

            // CPU writes come last so they override the sequencer (EN clear in INTR)
            if (wr_ctrl) begin
                en_n   = wdata[0];
                mode_n = wdata[2:1];
                im_n   = wdata[3];
            end
            if (wr_preset) preset_n = wdata;
`ifdef TC_COUNT_WRITE_EN
            if (wr_count) count_n = wdata;
`endif
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= IDLE;
                en      <= 1'b0;
                mode    <= 2'b00;
                im      <= 1'b0;
                preset  <= 32'd0;
                count   <= 32'd0;
                pending <= 1'b0;
            end else begin
                state   <= state_n;
                en      <= en_n;
                mode    <= mode_n;
                im      <= im_n;
                preset  <= preset_n;
                count   <= count_n;
                pending <= pending_n;
            end
        end

        assign irq[i]    = pending & im;
        assign rd_val[i] = (off == 2'd0) ? {28'd0, im, mode, en} :
                           (off == 2'd1) ? preset :
                           (off == 2'd2) ? count  : 32'd0;
    end

endmodule

// File: tb/tb_bridge_timer.sv
// tb/tb_bridge_timer.sv - scoreboard bench for bridge_timer decode, timers and interrupts

module tb_bridge_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic [1:0]  irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sbq [$];

    bridge_timer dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .hit   (hit),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic push(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] v;
        logic [31:0] addrs [6];
        logic        hits  [6];
        addrs = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F14, 32'h7F0C, 32'h8000};
        hits  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push("rst_rdata", 32'd0);
            push("rst_hit", {31'd0, hits[k]});
            rd(addrs[k], v);
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s @%h: got %h want %h", e.name, addrs[k], v, e.val); end
            v = {31'd0, hit};
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s @%h: got %h want %h", e.name, addrs[k], v, e.val); end
        end
        push("rst_irq", 32'd0);
        v = {30'd0, irq};
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
    endtask

    task automatic test_decode();
        exp_t        e;
        logic [31:0] v;
        logic [31:0] addrs [5];
        logic [31:0] want  [5];
        addrs = '{32'h7F0C, 32'h7F00, 32'h7F04, 32'h7F10, 32'h7F14};
        want  = '{32'd0, 32'h8, 32'h1234_5678, 32'd0, 32'd0};
        wr(32'h7F04, 32'h1234_5678);
        wr(32'h7F00, 32'hFFFF_FFF8);
        wr(32'h7F0C, 32'h0000_0001);
        wr(32'h8000, 32'h0000_0001);
        wr(32'h8004, 32'h0000_0001);
        for (int k = 0; k < 5; k++) begin
            push("dec_rdata", want[k]);
            rd(addrs[k], v);
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s @%h: got %h want %h", e.name, addrs[k], v, e.val); end
        end
        push("dec_hit_off3", 32'd0);
        rd(32'h7F0C, v);
        v = {31'd0, hit};
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        wr(32'h7F00, 32'd0);
    endtask

    task automatic test_oneshot();
        exp_t        e;
        logic [31:0] v;
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            push("os_count", 32'(5 - k));
            push("os_irq_low", 32'd0);
            rd(32'h7F08, v);
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s step %0d: got %h want %h", e.name, k, v, e.val); end
            v = {31'd0, irq[0]};
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s step %0d: got %h want %h", e.name, k, v, e.val); end
        end
        tick();
        push("os_irq_rise", 32'd1);
        push("os_ctrl_en_clr", 32'h8);
        v = {31'd0, irq[0]};
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        rd(32'h7F00, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        repeat (3) tick();
        push("os_irq_hold", 32'd1);
        v = {31'd0, irq[0]};
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        wr(32'h7F00, 32'h8);
        push("os_irq_clr", 32'd0);
        v = {31'd0, irq[0]};
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
    endtask

    task automatic test_autoreload();
        exp_t        e;
        logic [31:0] v;
        wr(32'h7F14, 32'd3);
        wr(32'h7F10, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            tick();
            push("ar_irq1", (k > 1 && (k % 5) == 1) ? 32'd1 : 32'd0);
            push("ar_irq0_indep", 32'd0);
            v = {31'd0, irq[1]};
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", e.name, k, v, e.val); end
            v = {31'd0, irq[0]};
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", e.name, k, v, e.val); end
        end
        tick();
        wr(32'h7F10, 32'd0);
        for (int k = 0; k < 8; k++) begin
            push("ar_stop_count", 32'd2);
            push("ar_stop_irq1", 32'd0);
            rd(32'h7F18, v);
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", e.name, k, v, e.val); end
            v = {31'd0, irq[1]};
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", e.name, k, v, e.val); end
            tick();
        end
    endtask

    task automatic test_masked();
        exp_t        e;
        logic [31:0] v;
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            push("im0_irq", 32'd0);
            v = {31'd0, irq[0]};
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", e.name, k, v, e.val); end
        end
        push("im0_ctrl_en_clr", 32'd0);
        rd(32'h7F00, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        wr(32'h7F00, 32'h8);
        for (int k = 0; k < 3; k++) begin
            push("im0_unmask_irq", 32'd0);
            v = {31'd0, irq[0]};
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", e.name, k, v, e.val); end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        exp_t        e;
        logic [31:0] v;
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'h9);
        repeat (4) tick();
        wr(32'h7F00, 32'h9);
        push("sc_ctrl_cpu_wins", 32'h9);
        push("sc_irq_set_wins", 32'd1);
        rd(32'h7F00, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        v = {31'd0, irq[0]};
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        repeat (2) tick();
        push("sc_reload_count", 32'd2);
        push("sc_irq_hold", 32'd1);
        rd(32'h7F08, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        v = {31'd0, irq[0]};
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        wr(32'h7F00, 32'd0);
        repeat (2) tick();
    endtask

    task automatic test_count_write();
        exp_t        e;
        logic [31:0] v;
        wr(32'h7F04, 32'd100);
        wr(32'h7F00, 32'h9);
        repeat (2) tick();
        push("cw_count_start", 32'd100);
        rd(32'h7F08, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        wr(32'h7F08, 32'd0);
`ifdef TC_COUNT_WRITE_EN
        push("cw_count_after_wr", 32'd0);
`else
        push("cw_count_after_wr", 32'd99);
`endif
        rd(32'h7F08, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        repeat (2) tick();
`ifdef TC_COUNT_WRITE_EN
        push("cw_count_late", 32'd0);
        push("cw_irq", 32'd1);
`else
        push("cw_count_late", 32'd97);
        push("cw_irq", 32'd0);
`endif
        rd(32'h7F08, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        v = {31'd0, irq[0]};
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        wr(32'h7F00, 32'd0);
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        logic [31:0] v;
        wr(32'h7F14, 32'd50);
        wr(32'h7F10, 32'hB);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push("rm_count", 32'd0);
        push("rm_ctrl", 32'd0);
        push("rm_preset", 32'd0);
        rd(32'h7F18, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        rd(32'h7F10, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        rd(32'h7F14, v);
        e = sbq.pop_front(); total++;
        if (v !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, v, e.val); end
        for (int k = 0; k < 60; k++) begin
            tick();
            push("rm_irq", 32'd0);
            v = {30'd0, irq};
            e = sbq.pop_front(); total++;
            if (v !== e.val) begin bad++; $display("FAIL %s cycle %0d: got %h want %h", e.name, k, v, e.val); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_decode();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_same_cycle();
        test_count_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
